pe_link_arbiter: RTL

// - Shares one outbound overlay link (out_to_east) between two requesters: the local PE result

---
 rtl/pe_overlay_pkg.sv | 18 +
 rtl/pe_link_out_reg.sv | 44 ++++
 rtl/pe_link_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pe_overlay_pkg.sv
// rtl/pe_overlay_pkg.sv - shared link-word layout and arbiter state encoding for the PE overlay
package pe_overlay_pkg;

  localparam int DATA_WIDTH_DEF = 130;
  localparam int LINK_LAST_BIT  = DATA_WIDTH_DEF - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  // The tail flag always rides in the top bit, whatever the link width.
  function automatic int link_last_bit(input int data_width);
    return data_width - 1;
  endfunction

endpackage

// File: rtl/pe_link_out_reg.sv
// rtl/pe_link_out_reg.sv - registered output stage of the east link (word + valid)
module pe_link_out_reg
  import pe_overlay_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;

  // The word only changes when a new beat lands; an empty load just clears valid.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_en) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/pe_link_arbiter.sv
// rtl/pe_link_arbiter.sv - packet-granular round-robin arbiter of local and south streams onto the east link
module pe_link_arbiter
  import pe_overlay_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int MAX_PKT_BEATS = 64,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ap_start,
  input  logic [DATA_WIDTH-1:0] in_local_data,
  input  logic                  in_local_valid,
  output logic                  in_local_ready,
  input  logic [DATA_WIDTH-1:0] in_from_south,
  input  logic                  in_south_valid,
  output logic                  in_south_ready,
  output logic [DATA_WIDTH-1:0] out_to_east,
  output logic                  out_east_valid,
  input  logic                  out_east_ready,
  output logic                  busy,
  output logic                  wdog_err,
  output logic [CNT_WIDTH-1:0]  pkt_cnt_local,
  output logic [CNT_WIDTH-1:0]  pkt_cnt_south
);

  localparam int                LAST_BIT   = link_last_bit(DATA_WIDTH);
  localparam int                BEAT_W     = $clog2(MAX_PKT_BEATS) + 1;
  localparam logic [BEAT_W-1:0] BEAT_LIMIT = BEAT_W'(MAX_PKT_BEATS - 1);

  arb_state_e            state_q, state_d;
  logic                  rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic                  wdog_err_q, wdog_err_d;
  logic [CNT_WIDTH-1:0]  cnt_local_q, cnt_local_d;
  logic [CNT_WIDTH-1:0]  cnt_south_q, cnt_south_d;

  logic                  load_en;
  logic                  acc_local, acc_south, beat_acc, beat_last;
  logic [DATA_WIDTH-1:0] beat_data;
  logic                  out_valid;

  // Downstream backpressure reaches the requesters only through their readies.
  assign load_en        = !out_valid || out_east_ready;
  assign in_local_ready = (state_q == LOCK0) && load_en;
  assign in_south_ready = (state_q == LOCK1) && load_en;
  assign acc_local      = in_local_valid && in_local_ready;
  assign acc_south      = in_south_valid && in_south_ready;
  assign beat_acc       = acc_local || acc_south;
  assign beat_data      = acc_south ? in_from_south : in_local_data;
  assign beat_last      = beat_data[LAST_BIT];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    wdog_err_d  = wdog_err_q;
    cnt_local_d = cnt_local_q;
    cnt_south_d = cnt_south_q;
    unique case (state_q)
      IDLE: begin
        if (ap_start && (in_local_valid || in_south_valid)) begin
          if (in_local_valid && in_south_valid) begin
            state_d = rr_ptr_q ? LOCK1 : LOCK0;
          end else begin
            state_d = in_south_valid ? LOCK1 : LOCK0;
          end
        end
      end
      LOCK0, LOCK1: begin
        if (beat_acc) begin
          if (beat_last) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            rr_ptr_d   = (state_q == LOCK0);
            if (acc_local && (cnt_local_q != '1)) begin
              cnt_local_d = cnt_local_q + CNT_WIDTH'(1);
            end
            if (acc_south && (cnt_south_q != '1)) begin
              cnt_south_d = cnt_south_q + CNT_WIDTH'(1);
            end
          end else begin
            // An overlong packet is flagged but still forwarded intact.
            if (beat_cnt_q == BEAT_LIMIT) begin
              wdog_err_d = 1'b1;
            end
            if (beat_cnt_q != '1) begin
              beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      beat_cnt_q  <= '0;
      wdog_err_q  <= 1'b0;
      cnt_local_q <= '0;
      cnt_south_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      wdog_err_q  <= wdog_err_d;
      cnt_local_q <= cnt_local_d;
      cnt_south_q <= cnt_south_d;
    end
  end

  pe_link_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .reset    (reset),
    .load_en  (load_en),
    .in_data  (beat_data),
    .in_valid (beat_acc),
    .out_data (out_to_east),
    .out_valid(out_valid)
  );

  assign out_east_valid = out_valid;
  assign busy           = (state_q != IDLE) || out_valid;
  assign wdog_err       = wdog_err_q;
  assign pkt_cnt_local  = cnt_local_q;
  assign pkt_cnt_south  = cnt_south_q;

endmodule
